// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: pixel-clock enable divider, h/v counters,
// registered sync/blank/coordinates, line/frame/animation strobes and frame counter.
module vga_timing_gen #(
  parameter int unsigned PIX_DIV    = 4,
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter logic        H_SYNC_POL = 1'b0,
  parameter logic        V_SYNC_POL = 1'b0,
  parameter int unsigned ANIM_X     = 5,
  parameter int unsigned ANIM_Y     = 492,
  parameter int unsigned X_W        = 10,
  parameter int unsigned Y_W        = 9,
  parameter int unsigned FC_W       = 16
) (
  input  logic            real100clock,
  input  logic            resetN,
  input  logic            enable,
  output logic            VGAclock,
  output logic            VGAsync,
  output logic            VGAblank,
  output logic            hsync,
  output logic            vsync,
  output logic [X_W-1:0]  xPixel,
  output logic [Y_W-1:0]  yPixel,
  output logic            lineStart,
  output logic            frameStart,
  output logic            animationCLOCK,
  output logic [FC_W-1:0] frameCount
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned D_W     = $clog2(PIX_DIV);
  // One spare code so the sync-end bound always fits when the back porch is 0.
  localparam int unsigned H_W     = $clog2(H_TOTAL + 1);
  localparam int unsigned V_W     = $clog2(V_TOTAL + 1);

  localparam logic [D_W-1:0] DIV_LAST = D_W'(PIX_DIV - 1);
  localparam logic [D_W-1:0] DIV_HALF = D_W'(PIX_DIV / 2);

  localparam logic [H_W-1:0] H_LAST   = H_W'(H_TOTAL - 1);
  localparam logic [H_W-1:0] H_ACT    = H_W'(H_ACTIVE);
  localparam logic [H_W-1:0] HS_START = H_W'(H_ACTIVE + H_FP);
  localparam logic [H_W-1:0] HS_END   = H_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [H_W-1:0] ANIM_XC  = H_W'(ANIM_X);

  localparam logic [V_W-1:0] V_LAST   = V_W'(V_TOTAL - 1);
  localparam logic [V_W-1:0] V_ACT    = V_W'(V_ACTIVE);
  localparam logic [V_W-1:0] VS_START = V_W'(V_ACTIVE + V_FP);
  localparam logic [V_W-1:0] VS_END   = V_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [V_W-1:0] ANIM_YC  = V_W'(ANIM_Y);

  logic [D_W-1:0]  divCntQ, divCntD;
  logic [H_W-1:0]  hCountQ, hCountD;
  logic [V_W-1:0]  vCountQ, vCountD;
  logic [FC_W-1:0] frameCountQ, frameCountD;
  logic            pixTick;
  logic            hActive, vActive, hSyncOn, vSyncOn;

  assign VGAsync    = 1'b0;
  assign frameCount = frameCountQ;
  assign pixTick    = enable && (divCntQ == DIV_LAST);

  always_comb begin
    divCntD = divCntQ;
    if (enable) begin
      divCntD = (divCntQ == DIV_LAST) ? '0 : divCntQ + D_W'(1);
    end
  end

  always_comb begin
    hCountD     = hCountQ;
    vCountD     = vCountQ;
    frameCountD = frameCountQ;
    if (pixTick) begin
      if (hCountQ == H_LAST) begin
        hCountD = '0;
        if (vCountQ == V_LAST) begin
          vCountD     = '0;
          frameCountD = frameCountQ + FC_W'(1);
        end else begin
          vCountD = vCountQ + V_W'(1);
        end
      end else begin
        hCountD = hCountQ + H_W'(1);
      end
    end
  end

  // Decode from the pre-advance counters; results land one pixel tick later.
  always_comb begin
    hActive = (hCountQ < H_ACT);
    vActive = (vCountQ < V_ACT);
    hSyncOn = (hCountQ >= HS_START) && (hCountQ < HS_END);
    vSyncOn = (vCountQ >= VS_START) && (vCountQ < VS_END);
  end

  always_ff @(posedge real100clock or negedge resetN) begin
    if (!resetN) begin
      divCntQ     <= '0;
      hCountQ     <= '0;
      vCountQ     <= '0;
      frameCountQ <= '0;
    end else begin
      divCntQ     <= divCntD;
      hCountQ     <= hCountD;
      vCountQ     <= vCountD;
      frameCountQ <= frameCountD;
    end
  end

  // VGAclock falls on the same edge the counters advance, so the DAC samples mid-pixel.
  always_ff @(posedge real100clock or negedge resetN) begin
    if (!resetN) begin
      VGAclock       <= 1'b0;
      VGAblank       <= 1'b0;
      hsync          <= ~H_SYNC_POL;
      vsync          <= ~V_SYNC_POL;
      xPixel         <= '0;
      yPixel         <= '0;
      lineStart      <= 1'b0;
      frameStart     <= 1'b0;
      animationCLOCK <= 1'b0;
    end else begin
      VGAclock <= (divCntD >= DIV_HALF);
      if (pixTick) begin
        VGAblank       <= hActive && vActive;
        hsync          <= hSyncOn ? H_SYNC_POL : ~H_SYNC_POL;
        vsync          <= vSyncOn ? V_SYNC_POL : ~V_SYNC_POL;
        xPixel         <= hActive ? X_W'(hCountQ) : '0;
        yPixel         <= vActive ? Y_W'(vCountQ) : '0;
        lineStart      <= (hCountQ == '0);
        frameStart     <= (hCountQ == '0) && (vCountQ == '0);
        animationCLOCK <= (hCountQ == ANIM_XC) && (vCountQ == ANIM_YC);
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default-geometry DUT for line/freeze timing, two small-geometry DUTs
// for frame, wrap, polarity, coincident-strobe and mid-frame reset behaviour.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  logic enable = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // dutA: default parameters
  logic aClk, aSync, aBlank, aHs, aVs, aLs, aFs, aAnim;
  logic [9:0]  aX;
  logic [8:0]  aY;
  logic [15:0] aFc;

  // dutB: PIX_DIV=2, 16x8 total, positive syncs, FC_W=2
  logic bClk, bSync, bBlank, bHs, bVs, bLs, bFs, bAnim;
  logic [2:0] bX;
  logic [1:0] bY;
  logic [1:0] bFc;

  // dutC: PIX_DIV=4, same small geometry, animation tick at (0,0)
  logic cClk, cSync, cBlank, cHs, cVs, cLs, cFs, cAnim;
  logic [3:0] cX;
  logic [2:0] cY;
  logic [3:0] cFc;

  vga_timing_gen dutA (
    .real100clock(clk), .resetN(resetN), .enable(enable),
    .VGAclock(aClk), .VGAsync(aSync), .VGAblank(aBlank), .hsync(aHs), .vsync(aVs),
    .xPixel(aX), .yPixel(aY), .lineStart(aLs), .frameStart(aFs),
    .animationCLOCK(aAnim), .frameCount(aFc)
  );

  vga_timing_gen #(
    .PIX_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .ANIM_X(5), .ANIM_Y(6),
    .X_W(3), .Y_W(2), .FC_W(2)
  ) dutB (
    .real100clock(clk), .resetN(resetN), .enable(enable),
    .VGAclock(bClk), .VGAsync(bSync), .VGAblank(bBlank), .hsync(bHs), .vsync(bVs),
    .xPixel(bX), .yPixel(bY), .lineStart(bLs), .frameStart(bFs),
    .animationCLOCK(bAnim), .frameCount(bFc)
  );

  vga_timing_gen #(
    .PIX_DIV(4), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .ANIM_X(0), .ANIM_Y(0), .X_W(4), .Y_W(3), .FC_W(4)
  ) dutC (
    .real100clock(clk), .resetN(resetN), .enable(enable),
    .VGAclock(cClk), .VGAsync(cSync), .VGAblank(cBlank), .hsync(cHs), .vsync(cVs),
    .xPixel(cX), .yPixel(cY), .lineStart(cLs), .frameStart(cFs),
    .animationCLOCK(cAnim), .frameCount(cFc)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    enable = 1'b1;
    resetN = 1'b0;
    repeat (10) step();
    checks++;
    if ({aHs, aVs, aBlank, aClk, aLs, aFs, aAnim, aSync} !== 8'b1100_0000) begin
      errors++;
      $display("FAIL reset_a_ctrl: got %b expected 11000000",
               {aHs, aVs, aBlank, aClk, aLs, aFs, aAnim, aSync});
    end
    checks++;
    if (aFc !== 16'd0 || aX !== 10'd0 || aY !== 9'd0) begin
      errors++;
      $display("FAIL reset_a_data: got fc=%0d x=%0d y=%0d expected 0 0 0", aFc, aX, aY);
    end
    checks++;
    if ({bHs, bVs, bBlank, bSync, cSync} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_b_pol: got %b expected 00000", {bHs, bVs, bBlank, bSync, cSync});
    end
    resetN = 1'b1;
    step();
    step();
    checks++;
    if (aClk !== 1'b1 || aFs !== 1'b0) begin
      errors++;
      $display("FAIL reset_edge2: got vgaclk=%b fs=%b expected 1 0", aClk, aFs);
    end
    step();
    checks++;
    if (aFs !== 1'b0) begin
      errors++;
      $display("FAIL reset_edge3_fs: got %b expected 0", aFs);
    end
    step();
    checks++;
    if ({aFs, aLs, aBlank, aClk} !== 4'b1110 || aX !== 10'd0 || aY !== 9'd0) begin
      errors++;
      $display("FAIL first_tick: got fs,ls,blank,clk=%b x=%0d y=%0d expected 1110 0 0",
               {aFs, aLs, aBlank, aClk}, aX, aY);
    end
    repeat (3) step();
    checks++;
    if (aFs !== 1'b1 || aLs !== 1'b1) begin
      errors++;
      $display("FAIL strobe_hold: got fs=%b ls=%b expected 1 1", aFs, aLs);
    end
    step();
    checks++;
    if (aFs !== 1'b0 || aLs !== 1'b0 || aX !== 10'd1) begin
      errors++;
      $display("FAIL strobe_width: got fs=%b ls=%b x=%0d expected 0 0 1", aFs, aLs, aX);
    end
  endtask

  task automatic test_line();
    int tL[2];
    int nL = 0;
    int hsFall = -1;
    int hsRise = -1;
    int blankCnt = 0;
    int xBad = 0;
    int xMax = 0;
    logic prevLs = aLs;
    logic prevHs = aHs;
    int prevX = int'(aX);
    tL[0] = 0;
    tL[1] = 0;
    for (int i = 0; i < 7000 && nL < 2; i++) begin
      step();
      if (aLs && !prevLs) begin
        tL[nL] = cyc;
        nL++;
      end
      if (nL == 1) begin
        if (aBlank) blankCnt++;
        if (!aHs && prevHs) hsFall = cyc;
        if (aHs && !prevHs) hsRise = cyc;
        if (int'(aX) != prevX) begin
          if (!(int'(aX) == prevX + 1 || (aX == 10'd0 && prevX == 639))) xBad++;
          if (int'(aX) > xMax) xMax = int'(aX);
        end
      end
      prevLs = aLs;
      prevHs = aHs;
      prevX = int'(aX);
    end
    checks++;
    if (nL != 2) begin
      errors++;
      $display("FAIL line_timeout: got %0d lineStarts expected 2", nL);
    end
    checks++;
    if (tL[1] - tL[0] != 3200) begin
      errors++;
      $display("FAIL line_period: got %0d expected 3200", tL[1] - tL[0]);
    end
    checks++;
    if (hsFall - tL[0] != 2624) begin
      errors++;
      $display("FAIL hsync_start: got %0d expected 2624", hsFall - tL[0]);
    end
    checks++;
    if (hsRise - hsFall != 384) begin
      errors++;
      $display("FAIL hsync_width: got %0d expected 384", hsRise - hsFall);
    end
    checks++;
    if (blankCnt != 2560) begin
      errors++;
      $display("FAIL blank_width: got %0d expected 2560", blankCnt);
    end
    checks++;
    if (xBad != 0 || xMax != 639) begin
      errors++;
      $display("FAIL x_sequence: got bad=%0d max=%0d expected 0 639", xBad, xMax);
    end
  endtask

  task automatic test_freeze();
    logic [35:0] snap;
    int found = 0;
    int diffs = 0;
    int lat = 0;
    for (int i = 0; i < 4000 && found == 0; i++) begin
      step();
      if (aX == 10'd100) found = 1;
    end
    checks++;
    if (found == 0) begin
      errors++;
      $display("FAIL freeze_find: got no x=100 expected x=100 within 4000 clocks");
    end
    step();
    step();
    enable = 1'b0;
    snap = {aClk, aBlank, aHs, aVs, aLs, aFs, aAnim, aX, aY, aFc[8:0]};
    repeat (50) begin
      step();
      if ({aClk, aBlank, aHs, aVs, aLs, aFs, aAnim, aX, aY, aFc[8:0]} !== snap) diffs++;
    end
    checks++;
    if (diffs != 0) begin
      errors++;
      $display("FAIL freeze_hold: got %0d changed samples expected 0", diffs);
    end
    enable = 1'b1;
    for (int i = 0; i < 10 && aX == 10'd100; i++) begin
      step();
      lat++;
    end
    checks++;
    if (aX !== 10'd101 || lat != 2) begin
      errors++;
      $display("FAIL freeze_resume: got x=%0d after %0d clocks expected 101 after 2", aX, lat);
    end
  endtask

  task automatic test_frames();
    int tF[5];
    int fc[5];
    int nF = 0;
    int tAnim = -1;
    int nAnim = 0;
    int animW = 0;
    int fsW = 0;
    int tVs = -1;
    int vsW = 0;
    int tLs = -1;
    int tHs = -1;
    int hsW = 0;
    logic prevFs = bFs;
    logic prevAn = bAnim;
    logic prevVs = bVs;
    logic prevHs = bHs;
    logic prevLs = bLs;
    for (int i = 0; i < 5; i++) begin
      tF[i] = 0;
      fc[i] = 0;
    end
    for (int i = 0; i < 2000 && nF < 5; i++) begin
      step();
      if (bFs && !prevFs) begin
        tF[nF] = cyc;
        fc[nF] = int'(bFc);
        nF++;
      end
      if (nF == 1) begin
        if (bFs) fsW++;
        if (bAnim && !prevAn) begin
          tAnim = cyc;
          nAnim++;
        end
        if (bAnim) animW++;
        if (bVs && !prevVs) tVs = cyc;
        if (bVs) vsW++;
        if (bLs && !prevLs && tLs < 0) tLs = cyc;
        if (bHs && !prevHs && tHs < 0) tHs = cyc;
        if (bHs && tHs >= 0 && cyc - tLs < 32) hsW++;
      end
      prevFs = bFs;
      prevAn = bAnim;
      prevVs = bVs;
      prevHs = bHs;
      prevLs = bLs;
    end
    checks++;
    if (nF != 5) begin
      errors++;
      $display("FAIL frame_timeout: got %0d frameStarts expected 5", nF);
    end
    checks++;
    if (tF[1] - tF[0] != 256 || tF[4] - tF[3] != 256) begin
      errors++;
      $display("FAIL frame_period: got %0d,%0d expected 256,256",
               tF[1] - tF[0], tF[4] - tF[3]);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (fc[k + 1] != (fc[k] + 1) % 4) begin
        errors++;
        $display("FAIL frame_count_%0d: got %0d expected %0d", k, fc[k + 1], (fc[k] + 1) % 4);
      end
    end
    checks++;
    if (nAnim != 1 || tAnim - tF[0] != 202 || animW != 2) begin
      errors++;
      $display("FAIL anim_tick: got n=%0d off=%0d w=%0d expected 1 202 2",
               nAnim, tAnim - tF[0], animW);
    end
    checks++;
    if (tVs - tF[0] != 160 || vsW != 64) begin
      errors++;
      $display("FAIL vsync_b: got off=%0d w=%0d expected 160 64", tVs - tF[0], vsW);
    end
    checks++;
    if (tHs - tLs != 20 || hsW != 6 || fsW != 2) begin
      errors++;
      $display("FAIL hsync_b: got off=%0d w=%0d fsw=%0d expected 20 6 2", tHs - tLs, hsW, fsW);
    end
  endtask

  task automatic test_coincident();
    int found = 0;
    logic prevFs = cFs;
    for (int i = 0; i < 1200 && found == 0; i++) begin
      step();
      if (cFs && !prevFs) found = 1;
      prevFs = cFs;
    end
    checks++;
    if (found == 0 || cAnim !== 1'b1 || cLs !== 1'b1) begin
      errors++;
      $display("FAIL coincident_rise: got found=%0d anim=%b ls=%b expected 1 1 1",
               found, cAnim, cLs);
    end
    repeat (3) step();
    checks++;
    if (cAnim !== 1'b1 || cFs !== 1'b1) begin
      errors++;
      $display("FAIL coincident_hold: got anim=%b fs=%b expected 1 1", cAnim, cFs);
    end
    step();
    checks++;
    if (cAnim !== 1'b0 || cFs !== 1'b0) begin
      errors++;
      $display("FAIL coincident_end: got anim=%b fs=%b expected 0 0", cAnim, cFs);
    end
  endtask

  task automatic test_async_reset();
    int found = 0;
    for (int i = 0; i < 600 && found == 0; i++) begin
      step();
      if (bY == 2'd2 && bX == 3'd3) found = 1;
    end
    checks++;
    if (found == 0) begin
      errors++;
      $display("FAIL areset_find: got no (3,2) expected (3,2) within 600 clocks");
    end
    #2;
    resetN = 1'b0;
    #1;
    checks++;
    if ({bHs, bVs, bBlank, bClk, bLs, bFs, bAnim} !== 7'b0 || bX !== 3'd0 ||
        bY !== 2'd0 || bFc !== 2'd0) begin
      errors++;
      $display("FAIL areset_async: got ctrl=%b x=%0d y=%0d fc=%0d expected 0000000 0 0 0",
               {bHs, bVs, bBlank, bClk, bLs, bFs, bAnim}, bX, bY, bFc);
    end
    repeat (3) step();
    resetN = 1'b1;
    step();
    checks++;
    if (bFs !== 1'b0 || bClk !== 1'b1) begin
      errors++;
      $display("FAIL areset_edge1: got fs=%b vgaclk=%b expected 0 1", bFs, bClk);
    end
    step();
    checks++;
    if ({bFs, bLs, bBlank} !== 3'b111 || bX !== 3'd0 || bY !== 2'd0) begin
      errors++;
      $display("FAIL areset_restart: got fs,ls,blank=%b x=%0d y=%0d expected 111 0 0",
               {bFs, bLs, bBlank}, bX, bY);
    end
  endtask

  initial begin
    test_reset();
    test_line();
    test_freeze();
    test_frames();
    test_coincident();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA timing generator, successor to the fixed 640x480 driver. Derives a pixel-clock enable from the system clock and runs horizontal/vertical counters. Produces sync, blank, pixel coordinates, line/frame strobes, a configurable animation tick and a frame counter. Feeds the sprite/colour logic and the external video DAC.

Parameters:
PIX_DIV, 4, system clocks per pixel (even, >=2)
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
H_SYNC_POL, 0, asserted level of hsync
V_SYNC_POL, 0, asserted level of vsync
ANIM_X, 5, horizontal count of animation tick (< H_TOTAL)
ANIM_Y, 492, vertical count of animation tick (< V_TOTAL)
X_W, 10, xPixel width; Y_W, 9, yPixel width; FC_W, 16, frameCount width

Ports:
real100clock  in  1  system clock, all logic on rising edge
resetN  in  1  asynchronous active-low reset
enable  in  1  1 = run, 0 = freeze divider, counters and outputs
VGAclock  out  1  pixel clock to DAC
VGAsync  out  1  DAC composite sync, tied 0
VGAblank  out  1  1 = active video (DAC blank_n)
hsync  out  1  horizontal sync, polarity H_SYNC_POL
vsync  out  1  vertical sync, polarity V_SYNC_POL
xPixel  out  X_W  column of presented pixel, 0 outside active
yPixel  out  Y_W  row of presented pixel, 0 outside active lines
lineStart  out  1  high for one pixel period at hCount 0
frameStart  out  1  high for one pixel period at (0,0)
animationCLOCK  out  1  high for one pixel period at (ANIM_X, ANIM_Y)
frameCount  out  FC_W  completed frames, wraps at 2^FC_W

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Order per line/frame: active, front porch, sync, back porch.
- Divider divCnt 0..PIX_DIV-1, increments each clock while enable=1; pixTick = enable & divCnt==PIX_DIV-1.
- VGAclock = (divCnt >= PIX_DIV/2), registered; counters advance on the VGAclock falling edge so the DAC samples mid-pixel.
- On pixTick: hCount increments; at H_TOTAL-1 wraps to 0 and vCount increments; vCount at V_TOTAL-1 with hCount wrap -> 0, frameCount+1 (modulo 2^FC_W).
- Outputs registered on pixTick from pre-advance counters: one pixel-tick latency; held constant between ticks and while enable=0.
- hsync asserted when H_ACTIVE+H_FP <= hCount < H_ACTIVE+H_FP+H_SYNC; vsync analogous on vCount (full lines).
- VGAblank = hCount<H_ACTIVE & vCount<V_ACTIVE; xPixel = hCount when hCount<H_ACTIVE else 0; yPixel = vCount when vCount<V_ACTIVE else 0; widths truncate.
- Strobes are exactly one pixel period (PIX_DIV clocks) wide, once per line/frame.
- Reset (any time, mid-frame included): divCnt, hCount, vCount, frameCount = 0; VGAclock 0; VGAblank 0; hsync = ~H_SYNC_POL; vsync = ~V_SYNC_POL; xPixel, yPixel, strobes 0. After release, first pixTick presents (0,0): VGAblank=1, lineStart=frameStart=1.
- enable falling mid-pixel: divCnt holds; resumes from same divCnt, no lost or duplicated pixel.
- Coincident ANIM (0,0): animationCLOCK and frameStart both high same period.

Test Plan:
- Reset, defaults: resetN low 10 clocks -> hsync=1, vsync=1, VGAblank=0, frameCount=0; first pixTick (4th clock after release) -> frameStart=lineStart=1 for 4 clocks, xPixel=0.
- Free-run one line: hsync low for 384 clocks starting 2624 clocks after lineStart; line period 3200 clocks; VGAblank high 2560 clocks; xPixel 0..639 then 0.
- Free-run frames: frameStart period 1,680,000 clocks; vsync low 6400 clocks starting at line 490; frameCount 0->1->2; one animationCLOCK per frame at line 492, pixel 5.
- Freeze: drop enable at xPixel=100 for 50 clocks -> all outputs constant; after resume xPixel continues 101 with no skip.
- Async reset mid-frame (line 300): outputs go to reset values without a clock edge; frame restarts at (0,0).
- Alt params PIX_DIV=2, H_SYNC_POL=1, FC_W=2: hsync high 192 clocks per 1600-clock line; frameCount wraps 3->0.
